// File: rtl/apb_pkg.sv
// Shared types and constants for the APB completer: FSM state encoding,
// bus widths and the fixed addresses of the ID and wait-state registers.
package apb_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    localparam logic [ADDR_W-1:0] ADDR_ID   = 8'hF0;
    localparam logic [ADDR_W-1:0] ADDR_WAIT = 8'hF1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_slave_if.sv
// APB-style bus bundle between a requester and this completer.
interface apb_slave_if;
    import apb_pkg::*;

    logic [1:0]        sel;
    logic              enable;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;

    modport master (output sel, enable, write, addr, wdata, input rdata, ready);
    modport slave  (input sel, enable, write, addr, wdata, output rdata, ready);

endinterface

// File: rtl/apb_slave_regfile.sv
// DEPTH x 8 data register bank: synchronous write, combinational read,
// asynchronous active-low clear.
module apb_slave_regfile
    import apb_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage array with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 8'h00;
            end
        end else if (wr_en) begin
            mem_r[wr_idx] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_idx];

endmodule

// File: rtl/apb_slave.sv
// APB completer with programmable wait states: IDLE/SETUP/ACCESS FSM, captured
// transfer attributes, address decode, ID and wait-state registers.
module apb_slave
    import apb_pkg::*;
#(
    parameter logic [1:0]        SLAVE_ID    = 2'd1,
    parameter logic [DATA_W-1:0] WAIT_CYCLES = 8'd2,
    parameter int                DEPTH       = 16
) (
    input  logic clk,
    input  logic reset,
    apb_slave_if.slave bus
);

    localparam int         IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] DEPTH_L = 9'(DEPTH);

    apb_state_t        state_r, next_state_s;
    logic [DATA_W-1:0] cnt_r, next_cnt_s;
    logic [DATA_W-1:0] wait_r;
    logic [ADDR_W-1:0] addr_cap_r;
    logic [DATA_W-1:0] wdata_cap_r;
    logic              write_cap_r;
    logic              ready_r, ready_nxt_s;
    logic [DATA_W-1:0] rdata_r, rdata_nxt_s;
    logic              sel_hit_s, capture_s, commit_s;
    logic              in_range_s, rf_wr_en_s;
    logic [DATA_W-1:0] rf_rd_data_s, rd_val_s;

    assign sel_hit_s  = (bus.sel == SLAVE_ID);
    assign in_range_s = ({1'b0, addr_cap_r} < DEPTH_L);
    assign rf_wr_en_s = commit_s && in_range_s;

    apb_slave_regfile #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_regfile (
        .clk     (clk),
        .rst_n   (reset),
        .wr_en   (rf_wr_en_s),
        .wr_idx  (addr_cap_r[IDX_W-1:0]),
        .wr_data (wdata_cap_r),
        .rd_idx  (addr_cap_r[IDX_W-1:0]),
        .rd_data (rf_rd_data_s)
    );

    // State, wait counter, captured attributes, wait register and output flops.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r     <= IDLE;
            cnt_r       <= 8'h00;
            wait_r      <= WAIT_CYCLES;
            addr_cap_r  <= 8'h00;
            wdata_cap_r <= 8'h00;
            write_cap_r <= 1'b0;
            ready_r     <= 1'b0;
            rdata_r     <= 8'h00;
        end else begin
            state_r <= next_state_s;
            cnt_r   <= next_cnt_s;
            ready_r <= ready_nxt_s;
            rdata_r <= rdata_nxt_s;
            if (capture_s) begin
                addr_cap_r  <= bus.addr;
                wdata_cap_r <= bus.wdata;
                write_cap_r <= bus.write;
            end
            if (commit_s && (addr_cap_r == ADDR_WAIT)) begin
                wait_r <= wdata_cap_r;
            end
        end
    end

    // Next-state logic; a write commits only when leaving the ready cycle.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        capture_s    = 1'b0;
        commit_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (sel_hit_s && !bus.enable) begin
                    next_state_s = SETUP;
                    capture_s    = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SETUP: begin
                if (sel_hit_s && bus.enable) begin
                    next_state_s = ACCESS;
                    next_cnt_s   = wait_r;
                end else begin
                    next_state_s = IDLE;
                    next_cnt_s   = 8'h00;
                end
            end
            ACCESS: begin
                if (cnt_r == 8'h00) begin
                    commit_s = write_cap_r;
                    if (sel_hit_s && !bus.enable) begin
                        next_state_s = SETUP;
                        capture_s    = 1'b1;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else if (sel_hit_s && bus.enable) begin
                    next_cnt_s = cnt_r - 8'd1;
                end else begin
                    next_state_s = IDLE;
                    next_cnt_s   = 8'h00;
                end
            end
            default: begin
                next_state_s = IDLE;
                next_cnt_s   = 8'h00;
            end
        endcase
    end

    // Read decode of the captured address.
    always_comb begin
        rd_val_s = 8'h00;
        if (in_range_s) begin
            rd_val_s = rf_rd_data_s;
        end else if (addr_cap_r == ADDR_ID) begin
            rd_val_s = {6'b0, SLAVE_ID};
        end else if (addr_cap_r == ADDR_WAIT) begin
            rd_val_s = wait_r;
        end else begin
            rd_val_s = 8'h00;
        end
    end

    // Outputs are precomputed from next state so ready/rdata come straight off flops.
    always_comb begin
        ready_nxt_s = (next_state_s == ACCESS) && (next_cnt_s == 8'h00);
        rdata_nxt_s = 8'h00;
        if (ready_nxt_s && !write_cap_r) begin
            rdata_nxt_s = rd_val_s;
        end else begin
            rdata_nxt_s = 8'h00;
        end
    end

    assign bus.ready = ready_r;
    assign bus.rdata = rdata_r;

endmodule

// File: tb/tb_apb_slave.sv
// Directed test of apb_slave: waits, ID/wait registers, back-to-back,
// deselected access, enable-drop abort and mid-transfer reset.
module tb_apb_slave;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] rd;
    int   rc;

    always #5 clk = ~clk;

    apb_slave_if bus ();

    apb_slave #(.SLAVE_ID(2'd1), .WAIT_CYCLES(8'd2), .DEPTH(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
        end
    endtask

    // One transfer; rc = access cycle in which ready was seen (0 = never within budget).
    task automatic xfer(input logic [1:0] s, input logic w, input logic [7:0] a,
                        input logic [7:0] d, output logic [7:0] rdv, output int rcv);
        rdv = 8'h00;
        rcv = 0;
        @(negedge clk);
        bus.sel = s; bus.enable = 1'b0; bus.write = w; bus.addr = a; bus.wdata = d;
        @(posedge clk);
        @(negedge clk);
        bus.enable = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk); #1;
            if (bus.ready === 1'b1) begin
                rcv = i;
                rdv = bus.rdata;
                break;
            end
        end
    endtask

    task automatic idle_chk(input int n);
        @(negedge clk);
        bus.sel = 2'd0; bus.enable = 1'b0; bus.write = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            check_val("idle ready", {31'd0, bus.ready}, 32'd0);
            check_val("idle rdata", {24'd0, bus.rdata}, 32'd0);
        end
    endtask

    initial begin
        bus.sel = 2'd0; bus.enable = 1'b0; bus.write = 1'b0;
        bus.addr = 8'h00; bus.wdata = 8'h00;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst ready", {31'd0, bus.ready}, 32'd0);
        check_val("rst rdata", {24'd0, bus.rdata}, 32'd0);
        reset = 1'b1;

        // Default wait of 2: ready in third access cycle.
        xfer(2'd1, 1'b1, 8'h03, 8'h5A, rd, rc);
        check_val("wr03 rc", rc, 32'd3);
        idle_chk(1);
        xfer(2'd1, 1'b0, 8'h03, 8'h00, rd, rc);
        check_val("rd03 rc", rc, 32'd3);
        check_val("rd03 data", {24'd0, rd}, 32'h5A);
        idle_chk(1);

        // Zero wait states; new value only applies from the next transfer.
        xfer(2'd1, 1'b1, 8'hF1, 8'h00, rd, rc);
        check_val("wrF1 rc", rc, 32'd3);
        idle_chk(1);
        xfer(2'd1, 1'b0, 8'h03, 8'h00, rd, rc);
        check_val("rd03 w0 rc", rc, 32'd1);
        check_val("rd03 w0 data", {24'd0, rd}, 32'h5A);
        idle_chk(1);
        xfer(2'd1, 1'b0, 8'hF0, 8'h00, rd, rc);
        check_val("rdF0 rc", rc, 32'd1);
        check_val("rdF0 data", {24'd0, rd}, 32'h01);
        idle_chk(1);

        // Back-to-back: second setup taken straight from ACCESS.
        xfer(2'd1, 1'b1, 8'h00, 8'h11, rd, rc);
        check_val("b2b wr rc", rc, 32'd1);
        xfer(2'd1, 1'b0, 8'h00, 8'h00, rd, rc);
        check_val("b2b rd rc", rc, 32'd1);
        check_val("b2b rd data", {24'd0, rd}, 32'h11);
        idle_chk(1);

        // Not selected, unmapped address, read-only ID.
        xfer(2'd2, 1'b1, 8'h01, 8'hFF, rd, rc);
        check_val("sel2 rc", rc, 32'd0);
        idle_chk(1);
        xfer(2'd1, 1'b0, 8'h01, 8'h00, rd, rc);
        check_val("rd01 rc", rc, 32'd1);
        check_val("rd01 data", {24'd0, rd}, 32'h00);
        idle_chk(1);
        xfer(2'd1, 1'b1, 8'h20, 8'hAB, rd, rc);
        idle_chk(1);
        xfer(2'd1, 1'b0, 8'h20, 8'h00, rd, rc);
        check_val("rd20 rc", rc, 32'd1);
        check_val("rd20 data", {24'd0, rd}, 32'h00);
        idle_chk(1);
        xfer(2'd1, 1'b1, 8'hF0, 8'h55, rd, rc);
        idle_chk(1);
        xfer(2'd1, 1'b0, 8'hF0, 8'h00, rd, rc);
        check_val("rdF0 ro", {24'd0, rd}, 32'h01);
        idle_chk(1);

        // Restore two wait states, then abort by dropping enable.
        xfer(2'd1, 1'b1, 8'hF1, 8'h02, rd, rc);
        idle_chk(1);
        xfer(2'd1, 1'b0, 8'hF1, 8'h00, rd, rc);
        check_val("rdF1 rc", rc, 32'd3);
        check_val("rdF1 data", {24'd0, rd}, 32'h02);
        idle_chk(1);
        @(negedge clk);
        bus.sel = 2'd1; bus.enable = 1'b0; bus.write = 1'b1; bus.addr = 8'h04; bus.wdata = 8'h77;
        @(posedge clk);
        @(negedge clk);
        bus.enable = 1'b1;
        @(posedge clk); #1;
        check_val("abort acc1 ready", {31'd0, bus.ready}, 32'd0);
        @(negedge clk);
        bus.enable = 1'b0;
        @(negedge clk);
        bus.sel = 2'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check_val("abort ready", {31'd0, bus.ready}, 32'd0);
        end
        xfer(2'd1, 1'b0, 8'h04, 8'h00, rd, rc);
        check_val("rd04 rc", rc, 32'd3);
        check_val("rd04 data", {24'd0, rd}, 32'h00);
        idle_chk(1);

        // Reset during the ready access cycle of a write.
        xfer(2'd1, 1'b1, 8'hF1, 8'h00, rd, rc);
        idle_chk(1);
        @(negedge clk);
        bus.sel = 2'd1; bus.enable = 1'b0; bus.write = 1'b1; bus.addr = 8'h05; bus.wdata = 8'h33;
        @(posedge clk);
        @(negedge clk);
        bus.enable = 1'b1;
        @(posedge clk); #1;
        check_val("pre-rst ready", {31'd0, bus.ready}, 32'd1);
        reset = 1'b0;
        #1;
        check_val("mid-rst ready", {31'd0, bus.ready}, 32'd0);
        check_val("mid-rst rdata", {24'd0, bus.rdata}, 32'd0);
        @(negedge clk);
        bus.sel = 2'd0; bus.enable = 1'b0; bus.write = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        xfer(2'd1, 1'b0, 8'h05, 8'h00, rd, rc);
        check_val("post-rst rd05 rc", rc, 32'd3);
        check_val("post-rst rd05", {24'd0, rd}, 32'h00);
        idle_chk(1);
        xfer(2'd1, 1'b0, 8'hF1, 8'h00, rd, rc);
        check_val("post-rst wait", {24'd0, rd}, 32'h02);
        idle_chk(1);
        xfer(2'd1, 1'b0, 8'h03, 8'h00, rd, rc);
        check_val("post-rst rd03", {24'd0, rd}, 32'h00);
        idle_chk(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
